// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the axi_to_mem write path: W payload geometry.
// Payload layout, MSB to LSB: {data, strb, last, user}.
package axi_to_mem_pkg;

    // Total payload width for a W beat.
    function automatic int unsigned w_payload_width(input int unsigned data_width,
                                                    input int unsigned user_width);
        return data_width + data_width / 8 + 1 + user_width;
    endfunction

    // Bit index of the last flag (user occupies the LSBs below it).
    function automatic int unsigned w_last_pos(input int unsigned user_width);
        return user_width;
    endfunction

    // LSB index of the strobe field.
    function automatic int unsigned w_strb_lsb(input int unsigned user_width);
        return user_width + 1;
    endfunction

    // LSB index of the data field.
    function automatic int unsigned w_data_lsb(input int unsigned data_width,
                                               input int unsigned user_width);
        return user_width + 1 + data_width / 8;
    endfunction

endpackage

// File: rtl/elastic_buf_ptr.sv
// Wrapping index pointer for the elastic buffer. Wraps Depth-1 -> 0, so
// Depth need not be a power of two. Clear has priority over increment.
module elastic_buf_ptr #(
    parameter  int unsigned Depth    = 4,
    localparam int unsigned PtrWidth = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [PtrWidth-1:0] ptr_o
);

    localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(Depth - 1);

    // Pointer register: reset/clear to zero, otherwise advance and wrap on increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= (ptr_o == LastIdx) ? '0 : ptr_o + PtrWidth'(1);
        end
    end

endmodule

// File: rtl/w_chan_elastic_buffer_flushable.sv
// Flushable, parametrised-depth elastic buffer for the AXI W-channel payload.
// Registered valid_o/ready_o (derived from the stored count plus flush_i only),
// no fall-through. flush_i masks both handshakes and empties the buffer.
// Optional macro W_ELASTIC_BUF_LAST_CNT_EN adds bursts_o, the number of stored
// beats carrying last=1.
module w_chan_elastic_buffer_flushable
    import axi_to_mem_pkg::*;
#(
    parameter  int unsigned DataWidth    = 32,
    parameter  int unsigned UserWidth    = 1,
    parameter  int unsigned Depth        = 4,
    parameter  bit          Bypass       = 1'b0,
    localparam int unsigned PayloadWidth = w_payload_width(DataWidth, UserWidth),
    localparam int unsigned UsageWidth   = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [PayloadWidth-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [PayloadWidth-1:0] data_o,
    output logic [UsageWidth-1:0]   usage_o
`ifdef W_ELASTIC_BUF_LAST_CNT_EN
    ,
    output logic [UsageWidth-1:0]   bursts_o
`endif
);

    if (Bypass) begin : g_bypass
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;
`ifdef W_ELASTIC_BUF_LAST_CNT_EN
        assign bursts_o = '0;
`endif
    end else begin : g_buffer
        localparam int unsigned PtrWidth = $clog2(Depth);

        logic [PtrWidth-1:0]     wr_ptr;
        logic [PtrWidth-1:0]     rd_ptr;
        logic [UsageWidth-1:0]   count;
        logic [PayloadWidth-1:0] entries [Depth];
        logic                    push;
        logic                    pop;

        // Flush masks both sides, so no handshake can complete in a flush cycle.
        assign valid_o = (count != '0) && !flush_i;
        assign ready_o = (count != UsageWidth'(Depth)) && !flush_i;
        assign push    = valid_i && ready_o;
        assign pop     = valid_o && ready_i;
        assign data_o  = entries[rd_ptr];
        assign usage_o = count;

        elastic_buf_ptr #(.Depth(Depth)) i_wr_ptr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (flush_i),
            .inc_i  (push),
            .ptr_o  (wr_ptr)
        );

        elastic_buf_ptr #(.Depth(Depth)) i_rd_ptr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (flush_i),
            .inc_i  (pop),
            .ptr_o  (rd_ptr)
        );

        // Occupancy: +1 push only, -1 pop only, cleared by flush.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                count <= '0;
            end else if (flush_i) begin
                count <= '0;
            end else if (push && !pop) begin
                count <= count + UsageWidth'(1);
            end else if (pop && !push) begin
                count <= count - UsageWidth'(1);
            end
        end

        // Storage: entry 0 is reset so data_o is deterministic out of reset;
        // the rest are plain data flops written only on push.
        for (genvar i = 0; i < Depth; i++) begin : g_entry
            logic [PayloadWidth-1:0] q;
            logic                    we;

            assign we         = push && (wr_ptr == PtrWidth'(i));
            assign entries[i] = q;

            if (i == 0) begin : g_rst
                // Head entry after reset: cleared, then loaded on push.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        q <= '0;
                    end else if (we) begin
                        q <= data_i;
                    end
                end
            end else begin : g_norst
                // Non-reset storage entry, loaded on push.
                always_ff @(posedge clk_i) begin
                    if (we) begin
                        q <= data_i;
                    end
                end
            end
        end

`ifdef W_ELASTIC_BUF_LAST_CNT_EN
        localparam int unsigned LastPos = w_last_pos(UserWidth);

        logic                  push_last;
        logic                  pop_last;
        logic [UsageWidth-1:0] bursts_q;

        assign push_last = push && data_i[LastPos];
        assign pop_last  = pop && data_o[LastPos];
        assign bursts_o  = bursts_q;

        // Count of complete bursts held: tracks last beats in and out.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                bursts_q <= '0;
            end else if (flush_i) begin
                bursts_q <= '0;
            end else if (push_last && !pop_last) begin
                bursts_q <= bursts_q + UsageWidth'(1);
            end else if (pop_last && !push_last) begin
                bursts_q <= bursts_q - UsageWidth'(1);
            end
        end
`else
        // Without the burst counter the last flag is stored but never inspected.
`endif
    end

endmodule

// File: tb/tb_w_chan_elastic_buffer_flushable.sv
// Directed bench for w_chan_elastic_buffer_flushable: a Depth=4 instance for
// the main scenarios and a Depth=3 instance for pointer wrap-around.
module tb_w_chan_elastic_buffer_flushable;

    localparam int PW = 38;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;

    logic          flush, valid_in, ready_out, valid_out, ready_in;
    logic [PW-1:0] data_in, data_out;
    logic [2:0]    usage;

    logic          f3, v3_i, r3_o, v3_o, r3_i;
    logic [PW-1:0] d3_i, d3_o;
    logic [1:0]    u3;

`ifdef W_ELASTIC_BUF_LAST_CNT_EN
    logic [2:0]    bursts;
    logic [1:0]    bursts3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    w_chan_elastic_buffer_flushable #(.DataWidth(32), .UserWidth(1), .Depth(4), .Bypass(1'b0)) dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_i  (data_in),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .data_o  (data_out),
        .usage_o (usage)
`ifdef W_ELASTIC_BUF_LAST_CNT_EN
        ,
        .bursts_o(bursts)
`endif
    );

    w_chan_elastic_buffer_flushable #(.DataWidth(32), .UserWidth(1), .Depth(3), .Bypass(1'b0)) dut3 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (f3),
        .valid_i (v3_i),
        .ready_o (r3_o),
        .data_i  (d3_i),
        .valid_o (v3_o),
        .ready_i (r3_i),
        .data_o  (d3_o),
        .usage_o (u3)
`ifdef W_ELASTIC_BUF_LAST_CNT_EN
        ,
        .bursts_o(bursts3)
`endif
    );

    function automatic logic [PW-1:0] mk(input logic [31:0] d, input logic last);
        return {d, 4'hF, last, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        flush = 0; valid_in = 0; ready_in = 0; data_in = '0;
        f3 = 0; v3_i = 0; r3_i = 0; d3_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
        n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL reset_usage got=%0d want=0", usage); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data got=%h want=0", data_out); end
`ifdef W_ELASTIC_BUF_LAST_CNT_EN
        n_cmp++; if (bursts !== 3'd0) begin n_bad++; $display("FAIL reset_bursts got=%0d want=0", bursts); end
`endif
    endtask

    task automatic test_fill_drain();
        ready_in = 0; valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = mk(32'hA0 + i, i[0]);
            #1;
            n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got=%b want=1", i, ready_out); end
            tick();
        end
        valid_in = 0;
        #1;
        n_cmp++; if (usage !== 3'd4) begin n_bad++; $display("FAIL full_usage got=%0d want=4", usage); end
        n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b want=0", ready_out); end
        n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL full_valid got=%b want=1", valid_out); end
        ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, valid_out); end
            n_cmp++; if (data_out !== mk(32'hA0 + i, i[0])) begin n_bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, data_out, mk(32'hA0 + i, i[0])); end
            tick();
            if (i == 0) begin
                n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL ready_after_pop got=%b want=1", ready_out); end
                n_cmp++; if (usage !== 3'd3) begin n_bad++; $display("FAIL usage_after_pop got=%0d want=3", usage); end
            end
        end
        ready_in = 0;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL empty_valid got=%b want=0", valid_out); end
        n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL empty_usage got=%0d want=0", usage); end
    endtask

    task automatic test_full_simul();
        ready_in = 0; valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = mk(32'hC0 + i, 1'b0);
            tick();
        end
        data_in = mk(32'hD0, 1'b0); ready_in = 1;
        #1;
        n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL fs_ready got=%b want=0", ready_out); end
        n_cmp++; if (data_out !== mk(32'hC0, 1'b0)) begin n_bad++; $display("FAIL fs_head got=%h want=%h", data_out, mk(32'hC0, 1'b0)); end
        tick();
        n_cmp++; if (usage !== 3'd3) begin n_bad++; $display("FAIL fs_usage0 got=%0d want=3", usage); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL fs_ready1 got=%b want=1", ready_out); end
        n_cmp++; if (data_out !== mk(32'hC1, 1'b0)) begin n_bad++; $display("FAIL fs_data0 got=%h want=%h", data_out, mk(32'hC1, 1'b0)); end
        // Beats D0, D1, D2 are accepted on the next three edges while C1..C3 leave.
        for (int k = 0; k < 3; k++) begin
            tick();
            data_in = mk(32'hD1 + k, 1'b0);
            n_cmp++; if (usage !== 3'd3) begin n_bad++; $display("FAIL fs_usage[%0d] got=%0d want=3", k, usage); end
            n_cmp++; if (data_out !== ((k == 2) ? mk(32'hD0, 1'b0) : mk(32'hC2 + k, 1'b0))) begin
                n_bad++; $display("FAIL fs_data[%0d] got=%h", k, data_out);
            end
        end
        valid_in = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (data_out !== mk(32'hD0 + i, 1'b0)) begin n_bad++; $display("FAIL fs_drain[%0d] got=%h want=%h", i, data_out, mk(32'hD0 + i, 1'b0)); end
            tick();
        end
        ready_in = 0;
        #1;
        n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL fs_empty got=%0d want=0", usage); end
    endtask

    task automatic test_flush();
        ready_in = 0; valid_in = 1;
        for (int i = 0; i < 3; i++) begin
            data_in = mk(32'hF0 + i, 1'b0);
            tick();
        end
        data_in = mk(32'hEE, 1'b0); flush = 1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b want=0", valid_out); end
        n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%b want=0", ready_out); end
        n_cmp++; if (usage !== 3'd3) begin n_bad++; $display("FAIL flush_usage_pre got=%0d want=3", usage); end
        tick();
        flush = 0; data_in = mk(32'h55, 1'b0);
        #1;
        n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL flush_usage_post got=%0d want=0", usage); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_valid_post got=%b want=0", valid_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL flush_ready_post got=%b want=1", ready_out); end
        tick();
        valid_in = 0;
        #1;
        n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL post_flush_valid got=%b want=1", valid_out); end
        n_cmp++; if (data_out !== mk(32'h55, 1'b0)) begin n_bad++; $display("FAIL post_flush_data got=%h want=%h", data_out, mk(32'h55, 1'b0)); end
        n_cmp++; if (usage !== 3'd1) begin n_bad++; $display("FAIL post_flush_usage got=%0d want=1", usage); end
        ready_in = 1;
        tick();
        ready_in = 0;
        #1;
        n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL post_flush_drain got=%0d want=0", usage); end
        // Flush held for several cycles with upstream still offering data.
        valid_in = 1; data_in = mk(32'h66, 1'b0);
        tick();
        flush = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (valid_out !== 1'b0 || ready_out !== 1'b0) begin
                n_bad++; $display("FAIL flush_hold[%0d] valid=%b ready=%b want 0/0", k, valid_out, ready_out);
            end
            tick();
            n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL flush_hold_usage[%0d] got=%0d want=0", k, usage); end
        end
        flush = 0; valid_in = 0;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_hold_end got=%b want=0", valid_out); end
    endtask

    task automatic test_reset_mid();
        ready_in = 0; valid_in = 1;
        data_in = mk(32'h71, 1'b1); tick();
        data_in = mk(32'h72, 1'b1); tick();
        valid_in = 0;
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (usage !== 3'd0) begin n_bad++; $display("FAIL arst_usage got=%0d want=0", usage); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b want=0", valid_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL arst_ready got=%b want=1", ready_out); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL arst_data got=%h want=0", data_out); end
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_depth3_stream();
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        while (out_idx < 10 && cyc < 300) begin
            v3_i = (in_idx < 10);
            d3_i = mk(32'hE0 + in_idx, in_idx[0]);
            r3_i = 1'($urandom_range(0, 1));
            #1;
            n_cmp++; if (u3 !== 2'(in_idx - out_idx)) begin n_bad++; $display("FAIL d3_usage got=%0d want=%0d", u3, in_idx - out_idx); end
            if (in_idx - out_idx == 3) begin
                n_cmp++; if (r3_o !== 1'b0) begin n_bad++; $display("FAIL d3_full_ready got=%b want=0", r3_o); end
            end
            if (v3_o && r3_i) begin
                n_cmp++; if (d3_o !== mk(32'hE0 + out_idx, out_idx[0])) begin
                    n_bad++; $display("FAIL d3_data[%0d] got=%h want=%h", out_idx, d3_o, mk(32'hE0 + out_idx, out_idx[0]));
                end
                out_idx++;
            end
            if (v3_i && r3_o) in_idx++;
            tick();
            cyc++;
        end
        v3_i = 0; r3_i = 0;
        n_cmp++; if (out_idx != 10) begin n_bad++; $display("FAIL d3_timeout got=%0d beats want=10", out_idx); end
    endtask

`ifdef W_ELASTIC_BUF_LAST_CNT_EN
    task automatic test_bursts();
        logic [3:0] lasts;
        lasts = 4'b1010;
        ready_in = 0; valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = mk(32'hB0 + i, lasts[i]);
            tick();
        end
        valid_in = 0;
        #1;
        n_cmp++; if (bursts !== 3'd2) begin n_bad++; $display("FAIL bursts_full got=%0d want=2", bursts); end
        ready_in = 1;
        tick(); tick();
        ready_in = 0;
        #1;
        n_cmp++; if (bursts !== 3'd1) begin n_bad++; $display("FAIL bursts_pop2 got=%0d want=1", bursts); end
        flush = 1;
        tick();
        flush = 0;
        #1;
        n_cmp++; if (bursts !== 3'd0) begin n_bad++; $display("FAIL bursts_flush got=%0d want=0", bursts); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_flush();
        test_reset_mid();
        test_depth3_stream();
`ifdef W_ELASTIC_BUF_LAST_CNT_EN
        test_bursts();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
